// File: rtl/i2c_wb_seq.sv
// i2c_wb_seq: WISHBONE master that turns byte register read/write commands into i2c_master_top register sequences.
// Define I2C_SEQ_IRQ_EN to wait on inta_i (followed by an SR read and IACK) instead of polling SR.
module i2c_wb_seq #(
    parameter logic [15:0] PRESCALE   = 16'h0031,
    parameter int          POLL_LIMIT = 1024
) (
    input  logic       wb_clk_i,
    input  logic       arst_i,
`ifdef I2C_SEQ_IRQ_EN
    input  logic       inta_i,
`endif
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_rw_i,
    input  logic [6:0] cmd_dev_i,
    input  logic [7:0] cmd_reg_i,
    input  logic [7:0] cmd_wdat_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdat_o,
    output logic [1:0] rsp_err_o,
    output logic       busy_o,
    output logic [2:0] wbm_adr_o,
    output logic [7:0] wbm_dat_o,
    input  logic [7:0] wbm_dat_i,
    output logic       wbm_we_o,
    output logic       wbm_stb_o,
    output logic       wbm_cyc_o,
    input  logic       wbm_ack_i
);
`ifdef I2C_SEQ_IRQ_EN
    localparam int         LIM   = POLL_LIMIT * 16;
    localparam logic [7:0] CTR_V = 8'hC0;
`else
    localparam int         LIM   = POLL_LIMIT;
    localparam logic [7:0] CTR_V = 8'h80;
`endif
    localparam int            CW    = $clog2(LIM + 1);
    localparam logic [CW-1:0] LIM_V = LIM[CW-1:0];

    typedef enum logic [3:0] {INIT_PL, INIT_PH, INIT_CTR, IDLE, TXR, CR, WAIT, SRD, IACK, CHK, STOP, RXR, RESP} state_t;

    state_t        state;
    logic          rw_q, al_q, rx_q, acc, a_we, last;
    logic [6:0]    dev_q;
    logic [7:0]    reg_q, wdat_q, txr_v, cr_v, a_dat;
    logic [1:0]    step, err_q;
    logic [2:0]    a_adr;
    logic [CW-1:0] cnt;

    // Step 3 exists only for reads: the CR-only receive byte after the repeated start.
    always_comb begin
        txr_v = step == 2'd0 ? {dev_q, 1'b0} : step == 2'd1 ? reg_q : rw_q ? {dev_q, 1'b1} : wdat_q;
        cr_v  = step == 2'd0 ? 8'h90 : step == 2'd1 ? 8'h10 : !rw_q ? 8'h50 : step == 2'd2 ? 8'h90 : 8'h68;
        last  = rw_q ? step == 2'd3 : step == 2'd2;
        acc   = 1'b1;
        a_we  = 1'b1;
        a_adr = 3'd4;
        a_dat = 8'h00;
        case (state)
            INIT_PL:  begin a_adr = 3'd0; a_dat = PRESCALE[7:0]; end
            INIT_PH:  begin a_adr = 3'd1; a_dat = PRESCALE[15:8]; end
            INIT_CTR: begin a_adr = 3'd2; a_dat = CTR_V; end
            TXR:      begin a_adr = 3'd3; a_dat = txr_v; end
            CR:       a_dat = cr_v;
            STOP:     a_dat = 8'h40;
            RXR:      begin a_we = 1'b0; a_adr = 3'd3; end
`ifdef I2C_SEQ_IRQ_EN
            SRD:      a_we = 1'b0;
            IACK:     a_dat = 8'h01;
`else
            WAIT:     a_we = 1'b0;
`endif
            default:  acc = 1'b0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
            state       <= INIT_PL;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_adr_o   <= 3'd0;
            wbm_dat_o   <= 8'h00;
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdat_o  <= 8'h00;
            rsp_err_o   <= 2'd0;
            busy_o      <= 1'b1;
            rw_q        <= 1'b0;
            dev_q       <= 7'd0;
            reg_q       <= 8'h00;
            wdat_q      <= 8'h00;
            step        <= 2'd0;
            err_q       <= 2'd0;
            al_q        <= 1'b0;
            rx_q        <= 1'b0;
            cnt         <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            if (acc && !wbm_cyc_o) begin
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                wbm_we_o  <= a_we;
                wbm_adr_o <= a_adr;
                wbm_dat_o <= a_dat;
            end else if (acc && wbm_ack_i) begin
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                wbm_we_o  <= 1'b0;
                wbm_adr_o <= 3'd0;
                wbm_dat_o <= 8'h00;
                case (state)
                    INIT_PL:  state <= INIT_PH;
                    INIT_PH:  state <= INIT_CTR;
                    INIT_CTR: begin state <= IDLE; cmd_ready_o <= 1'b1; busy_o <= 1'b0; end
                    TXR:      state <= CR;
                    CR:       begin state <= WAIT; cnt <= '0; end
                    STOP:     state <= RESP;
                    RXR:      begin rsp_rdat_o <= wbm_dat_i; state <= RESP; end
`ifdef I2C_SEQ_IRQ_EN
                    SRD:      begin al_q <= wbm_dat_i[5]; rx_q <= wbm_dat_i[7]; state <= IACK; end
                    IACK:     state <= CHK;
`else
                    WAIT: begin
                        al_q <= wbm_dat_i[5];
                        rx_q <= wbm_dat_i[7];
                        cnt  <= cnt + 1'b1;
                        if (!wbm_dat_i[1]) state <= CHK;
                        else if (cnt + 1'b1 >= LIM_V) begin err_q <= 2'd3; state <= STOP; end
                    end
`endif
                    default: ;
                endcase
            end else if (!acc) begin
                case (state)
                    IDLE: if (cmd_valid_i && cmd_ready_o) begin
                        rw_q        <= cmd_rw_i;
                        dev_q       <= cmd_dev_i;
                        reg_q       <= cmd_reg_i;
                        wdat_q      <= cmd_wdat_i;
                        step        <= 2'd0;
                        err_q       <= 2'd0;
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        state       <= TXR;
                    end
`ifdef I2C_SEQ_IRQ_EN
                    WAIT: if (inta_i) state <= SRD;
                    else begin
                        cnt <= cnt + 1'b1;
                        if (cnt + 1'b1 >= LIM_V) begin err_q <= 2'd3; state <= STOP; end
                    end
`endif
                    CHK: if (al_q) begin err_q <= 2'd2; state <= RESP; end
                    else if (rx_q && !(rw_q && step == 2'd3)) begin err_q <= 2'd1; state <= STOP; end
                    else if (last) state <= rw_q ? RXR : RESP;
                    else begin
                        step  <= step + 2'd1;
                        state <= (rw_q && step == 2'd2) ? CR : TXR;
                    end
                    RESP: begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= err_q;
                        if (rw_q && err_q != 2'd0) rsp_rdat_o <= 8'h00;
                        cmd_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                        state       <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_wb_seq.sv
// tb_i2c_wb_seq: self-checking bench; a scripted i2c_master_top register model answers the sequencer,
// and a transaction-level model predicts the bus accesses and the response of each command.
module tb_i2c_wb_seq;
    localparam int LIM = 4;

    typedef struct packed {
        logic           rw;
        logic [6:0]     dev;
        logic [7:0]     rg;
        logic [7:0]     wdat;
        logic [3:0][3:0] tips;
        logic [3:0]     nack;
        logic [3:0]     al;
        logic [7:0]     rxr;
        logic [1:0]     err;
        logic [7:0]     rdat;
    } vec_t;

    logic       clk = 1'b0, arst_i;
    logic       cmd_valid, cmd_ready, cmd_rw, rsp_valid, busy;
    logic [6:0] cmd_dev;
    logic [7:0] cmd_reg, cmd_wdat, rsp_rdat;
    logic [1:0] rsp_err;
    logic [2:0] wbm_adr_o;
    logic [7:0] wbm_dat_o, wbm_dat_i;
    logic       wbm_we_o, wbm_stb_o, wbm_cyc_o, wbm_ack_i;

    int checks, errors;
    int nb, cur, tip_left, wl;
    bit rand_lat;
    vec_t sc;
    vec_t vt[8];
    logic [11:0] log[$];
    logic [11:0] exp_q[$];
    logic [1:0] m_err;
    logic [7:0] m_rdat;

    always #5 clk = ~clk;

    i2c_wb_seq #(.PRESCALE(16'h0031), .POLL_LIMIT(LIM)) dut (
        .wb_clk_i(clk), .arst_i(arst_i),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_rw_i(cmd_rw),
        .cmd_dev_i(cmd_dev), .cmd_reg_i(cmd_reg), .cmd_wdat_i(cmd_wdat),
        .rsp_valid_o(rsp_valid), .rsp_rdat_o(rsp_rdat), .rsp_err_o(rsp_err), .busy_o(busy),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
        .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o), .wbm_ack_i(wbm_ack_i)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Core register model: TIP stays set for the scripted number of SR reads after each byte-start CR write.
    initial begin wbm_ack_i = 1'b0; wbm_dat_i = 8'h00; nb = 0; cur = 0; tip_left = 0; wl = 0; end
    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) nb <= 0;
        if (wbm_ack_i) wbm_ack_i <= 1'b0;
        else if (wbm_cyc_o && wbm_stb_o) begin
            if (wl > 0) wl <= wl - 1;
            else begin
                wbm_ack_i <= 1'b1;
                wl <= rand_lat ? int'($urandom_range(0, 2)) : 0;
                log.push_back({wbm_we_o, wbm_adr_o, wbm_we_o ? wbm_dat_o : 8'h00});
                if (wbm_we_o && wbm_adr_o == 3'd4 && wbm_dat_o != 8'h40) begin
                    tip_left <= int'(sc.tips[nb]);
                    cur <= nb;
                    nb <= nb + 1;
                end
                if (!wbm_we_o && wbm_adr_o == 3'd4) begin
                    if (tip_left > 0) begin tip_left <= tip_left - 1; wbm_dat_i <= 8'h02; end
                    else wbm_dat_i <= {sc.nack[cur], 1'b0, sc.al[cur], 5'b0};
                end
                if (!wbm_we_o && wbm_adr_o == 3'd3) wbm_dat_i <= sc.rxr;
            end
        end
    end

    // Bus protocol watch: signals stable until ack, and an idle cycle after every ack.
    bit pc = 1'b0, pa = 1'b0;
    logic [12:0] pv;
    always @(negedge clk) begin
        if (arst_i) begin pc = 1'b0; pa = 1'b0; end
        else begin
            if (pa) chk("idle_after_ack", {wbm_cyc_o, wbm_stb_o}, 0);
            else if (pc && wbm_cyc_o) chk("bus_stable", {wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o}, pv);
            pc = wbm_cyc_o;
            pa = wbm_ack_i && wbm_cyc_o;
            pv = {wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o};
        end
    end

    function automatic vec_t mk(input logic rw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wdat,
                                input logic [15:0] tips, input logic [3:0] nack, input logic [3:0] al,
                                input logic [7:0] rxr, input logic [1:0] err, input logic [7:0] rdat);
        vec_t v;
        v.rw = rw; v.dev = dev; v.rg = rg; v.wdat = wdat; v.tips = tips;
        v.nack = nack; v.al = al; v.rxr = rxr; v.err = err; v.rdat = rdat;
        return v;
    endfunction

    // Transaction-level prediction: byte list per command type, then per-byte poll/abort rules.
    task automatic model(input vec_t v);
        logic [7:0] tx[4];
        logic [7:0] cr[4];
        int n;
        exp_q.delete();
        m_err = 2'd0;
        n = v.rw ? 4 : 3;
        tx[0] = {v.dev, 1'b0}; tx[1] = v.rg; tx[2] = v.rw ? {v.dev, 1'b1} : v.wdat; tx[3] = 8'h00;
        cr[0] = 8'h90; cr[1] = 8'h10; cr[2] = v.rw ? 8'h90 : 8'h50; cr[3] = 8'h68;
        for (int b = 0; b < n; b++) begin
            if (b < 3) exp_q.push_back({4'b1011, tx[b]});
            exp_q.push_back({4'b1100, cr[b]});
            if (int'(v.tips[b]) >= LIM) begin
                repeat (LIM) exp_q.push_back(12'h400);
                exp_q.push_back(12'hC40);
                m_err = 2'd3;
                break;
            end
            repeat (int'(v.tips[b]) + 1) exp_q.push_back(12'h400);
            if (v.al[b]) begin m_err = 2'd2; break; end
            if (v.nack[b] && b < 3) begin exp_q.push_back(12'hC40); m_err = 2'd1; break; end
        end
        if (v.rw && m_err == 2'd0) exp_q.push_back(12'h300);
        if (v.rw) m_rdat = m_err == 2'd0 ? v.rxr : 8'h00;
    endtask

    task automatic cmp_log(input string name);
        chk({name, " len"}, log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log.size(); i++)
            chk($sformatf("%s acc%0d", name, i), log[i], exp_q[i]);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
        chk({name, " ready"}, cmd_ready, 1);
    endtask

    task automatic run(input vec_t v, input string name, input bit tbl);
        int n = 0;
        sc = v;
        model(v);
        wait_ready(name);
        log.delete();
        cmd_rw = v.rw; cmd_dev = v.dev; cmd_reg = v.rg; cmd_wdat = v.wdat; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk({name, " ready_drop"}, cmd_ready, 0);
        chk({name, " busy"}, busy, 1);
        while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
        chk({name, " rsp_valid"}, rsp_valid, 1);
        chk({name, " err"}, rsp_err, tbl ? v.err : m_err);
        chk({name, " rdat"}, rsp_rdat, tbl ? v.rdat : m_rdat);
        cmp_log(name);
        @(negedge clk);
        chk({name, " pulse"}, rsp_valid, 0);
    endtask

    initial begin
        int k, n, seen;
        bit p;
        vec_t v;
        checks = 0; errors = 0; rand_lat = 1'b0; m_rdat = 8'h00;
        cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_dev = 7'd0; cmd_reg = 8'h00; cmd_wdat = 8'h00; sc = '0;
        arst_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst cyc", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 0);
        chk("rst ready", cmd_ready, 0);
        chk("rst busy", busy, 1);
        chk("rst rsp", {rsp_valid, rsp_err, rsp_rdat}, 0);
        log.delete();
        arst_i = 1'b0;
        wait_ready("init");
        chk("init busy", busy, 0);
        exp_q = '{12'h831, 12'h900, 12'hA80};
        cmp_log("init");

        vt[0] = mk(1'b0, 7'h50, 8'h10, 8'hA5, 16'h0010, 4'h0, 4'h0, 8'h00, 2'd0, 8'h00);
        vt[1] = mk(1'b1, 7'h50, 8'h02, 8'h00, 16'h0201, 4'h0, 4'h0, 8'h3C, 2'd0, 8'h3C);
        vt[2] = mk(1'b0, 7'h50, 8'h10, 8'h5A, 16'h0000, 4'h1, 4'h0, 8'h00, 2'd1, 8'h3C);
        vt[3] = mk(1'b1, 7'h21, 8'h40, 8'h00, 16'h0090, 4'h0, 4'h0, 8'h77, 2'd3, 8'h00);
        vt[4] = mk(1'b0, 7'h33, 8'h01, 8'hFF, 16'h0000, 4'h0, 4'h4, 8'h00, 2'd2, 8'h00);
        vt[5] = mk(1'b1, 7'h7F, 8'hFE, 8'h00, 16'h0000, 4'h8, 4'h0, 8'hC3, 2'd0, 8'hC3);
        vt[6] = mk(1'b1, 7'h08, 8'h11, 8'h00, 16'h0000, 4'h4, 4'h0, 8'h55, 2'd1, 8'h00);
        vt[7] = mk(1'b0, 7'h12, 8'h34, 8'h56, 16'h0003, 4'h0, 4'h0, 8'h00, 2'd0, 8'h00);
        for (int i = 0; i < 8; i++) run(vt[i], $sformatf("vec%0d", i), 1'b1);

        // Reset while the third access (first SR poll) of a write is on the bus.
        sc = vt[0];
        wait_ready("arst");
        cmd_rw = 1'b0; cmd_dev = 7'h50; cmd_reg = 8'h10; cmd_wdat = 8'hA5; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0; n = 0; p = 1'b0;
        while (k < 3 && n < 200) begin
            @(negedge clk);
            if (wbm_cyc_o && !p) k++;
            p = wbm_cyc_o;
            n++;
        end
        chk("arst third_access", k, 3);
        arst_i = 1'b1;
        #1;
        chk("arst cyc_drop", {wbm_cyc_o, wbm_stb_o}, 0);
        chk("arst busy", busy, 1);
        log.delete();
        m_rdat = 8'h00;
        @(negedge clk);
        @(negedge clk);
        arst_i = 1'b0;
        n = 0; seen = 0;
        while (!cmd_ready && n < 300) begin @(negedge clk); if (rsp_valid) seen++; n++; end
        chk("arst ready", cmd_ready, 1);
        chk("arst no_rsp", seen, 0);
        exp_q = '{12'h831, 12'h900, 12'hA80};
        cmp_log("arst init");

        rand_lat = 1'b1;
        for (int i = 0; i < 40; i++) begin
            v = '0;
            v.rw = 1'($urandom);
            v.dev = 7'($urandom);
            v.rg = 8'($urandom);
            v.wdat = 8'($urandom);
            v.rxr = 8'($urandom);
            for (int b = 0; b < 4; b++) begin
                v.tips[b] = ($urandom_range(0, 9) == 0) ? 4'(4 + $urandom_range(0, 11)) : 4'($urandom_range(0, 2));
                v.nack[b] = ($urandom_range(0, 7) == 0);
                v.al[b] = ($urandom_range(0, 15) == 0);
            end
            run(v, $sformatf("rand%0d", i), 1'b0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_wb_seq.md
Name: i2c_wb_seq

Overview:
- WISHBONE master sequencer that sits directly upstream of the i2c_master_top core and drives its register slave port.
- Converts single-shot register-access commands (write byte / read byte to device+register) into the core's PRER/CTR/TXR/CR write sequence and SR polling.
- Returns read data and a completion status to a simple valid/ready client.
- Programs the prescaler and enables the core once after reset.

Parameters:
PRESCALE, 16'h0031, value written to PRERlo/PRERhi during init
POLL_LIMIT, 1024, maximum SR reads per TIP wait before timeout; minimum 2

Ports:
wb_clk_i  in  1  clock
arst_i  in  1  asynchronous reset, active-high
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  sequencer idle, accepts command
cmd_rw_i  in  1  1=read, 0=write
cmd_dev_i  in  7  7-bit I2C device address
cmd_reg_i  in  8  device register address
cmd_wdat_i  in  8  write data
rsp_valid_o  out  1  one-cycle completion pulse
rsp_rdat_o  out  8  read data, valid with rsp_valid_o
rsp_err_o  out  2  00 ok, 01 NACK, 10 arbitration lost, 11 timeout
busy_o  out  1  high from init start until return to IDLE
wbm_adr_o  out  3  core register address
wbm_dat_o  out  8  write data to core
wbm_dat_i  in  8  read data from core
wbm_we_o  out  1  write enable
wbm_stb_o  out  1  strobe
wbm_cyc_o  out  1  cycle
wbm_ack_i  in  1  core acknowledge

Behaviour:
- Reset, async, active-high. Outputs reset to: all wbm_* = 0, cmd_ready_o=0, rsp_valid_o=0, rsp_rdat_o=0, rsp_err_o=0, busy_o=1. State = INIT_PL.
- Core register map: 0 PRERlo, 1 PRERhi, 2 CTR (EN=bit7, IEN=bit6), 3 TXR/RXR, 4 CR/SR.
  - CR bits: STA7, STO6, RD5, WR4, ACK3, IACK0.
  - SR bits: RxACK7, BUSY6, AL5, TIP1, IF0.
- Bus access:
  - cyc, stb, we, adr and dat are asserted together and held stable until wbm_ack_i.
  - All are dropped in the cycle after the ack is sampled.
  - At least one idle cycle separates consecutive accesses.
  - No timeout on wbm_ack_i.
- Init: write PRERlo=PRESCALE[7:0], then PRERhi=PRESCALE[15:8], then CTR=8'h80. Then go to IDLE.
- IDLE:
  - cmd_ready_o=1, busy_o=0.
  - Accept on cmd_valid_i && cmd_ready_o; latch all cmd_* fields. cmd_ready_o drops the next cycle.
- Byte step: write TXR, write CR, then WAIT.
- WAIT:
  - Repeatedly read SR until TIP=0.
  - Each read increments the poll counter; the counter is cleared at every byte step.
  - If the counter reaches POLL_LIMIT while TIP is still 1, error = 11.
  - On TIP=0, check in this order: AL=1 gives error 10; otherwise RxACK=1 on an address/TX byte gives error 01.
- Write command sequence:
  - TXR={dev,0}, CR=8'h90
  - TXR=reg, CR=8'h10
  - TXR=wdat, CR=8'h50
- Read command sequence:
  - TXR={dev,0}, CR=8'h90
  - TXR=reg, CR=8'h10
  - TXR={dev,1}, CR=8'h90 (repeated start)
  - CR=8'h68 (read, NACK, stop); wait; read RXR into rsp_rdat_o
  - RxACK is not checked on the final read byte.
- Error handling:
  - On NACK or timeout: write CR=8'h40 (stop), skip the wait, and respond.
  - On AL: respond immediately; no stop is issued.
  - Remaining steps are abandoned.
- Response:
  - rsp_valid_o pulses 1 cycle with rsp_err_o.
  - rsp_rdat_o holds the last RXR value until the next read completes; it is 0 on errored reads.
  - Return to IDLE in the same transition.
- cmd_valid_i while not ready is ignored; the client holds it.
- Reset mid-transfer:
  - The bus is released asynchronously (cyc/stb=0). No response is produced for the aborted command.
  - Init reruns.

Optional Feature:
- Macro: I2C_SEQ_IRQ_EN
- Defined:
  - Adds input port inta_i (1 bit).
  - Init writes CTR=8'hC0.
  - WAIT idles the bus until inta_i=1, then does one SR read for status and writes CR=8'h01 (IACK) before continuing.
  - The timeout counts clock cycles spent waiting for inta_i, against POLL_LIMIT×16.
- Undefined: no inta_i port, CTR=8'h80, polling as above.

Test Plan:
- Reset release, core acks every access in 1 cycle -> writes (0,8'h31), (1,8'h00), (2,8'h80) in order, then cmd_ready_o=1, busy_o=0.
- Write command dev=7'h50, reg=8'h10, wdat=8'hA5, core model ACKs all bytes -> TXR writes 8'hA0/8'h10/8'hA5 with CR 8'h90/8'h10/8'h50; rsp_err_o=00.
- Read command dev=7'h50, reg=8'h02, RXR model=8'h3C -> TXR 8'hA0, 8'h02, 8'hA1; CR 8'h90, 8'h10, 8'h90, 8'h68; rsp_rdat_o=8'h3C, rsp_err_o=00.
- Address NACK (SR=8'h80 after first byte) -> CR=8'h40 written, rsp_err_o=01, no TXR=reg write.
- TIP stuck at 1 with POLL_LIMIT=4 -> exactly 4 SR reads, CR=8'h40, rsp_err_o=11; AL=1 case -> rsp_err_o=10, no stop.
- arst_i pulse during the third bus access -> wbm_cyc_o=0 the same cycle, no rsp_valid_o, init sequence restarts.
